// File: rtl/seg7_scan8_if.sv
// Digit bus from the BCD counter plus the 7-segment pin bundle for seg7_scan8.
interface seg7_scan8_if;
    logic [3:0] ones, tens, hundreds, thousands;
    logic [3:0] tenthousands, hundredthousands, millions, tenmillions;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output ones, tens, hundreds, thousands,
               tenthousands, hundredthousands, millions, tenmillions,
        input  an, seg, dp, frame_tick
    );
    modport slave (
        input  ones, tens, hundreds, thousands,
               tenthousands, hundredthousands, millions, tenmillions,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg7_scan8.sv
// 8-digit common-anode scanner with per-frame snapshot and inter-digit blanking.
// Optional SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros above DP_POS.
module seg7_scan8 #(
    parameter int DWELL_CYC = 1000,
    parameter int BLANK_CYC = 50,
    parameter int DP_POS    = 1
) (
    input logic         clk,
    input logic         rst,
    seg7_scan8_if.slave bus
);
    localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, nstate;
    logic [2:0]    idx, nidx;
    logic [CW-1:0] cnt, ncnt;
    logic          cap;
    logic [3:0]    din  [8];
    logic [3:0]    snap [8];
    logic [3:0]    cur  [8];
    logic [7:0]    lzb;
    logic [7:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign din[0] = bus.ones;
    assign din[1] = bus.tens;
    assign din[2] = bus.hundreds;
    assign din[3] = bus.thousands;
    assign din[4] = bus.tenthousands;
    assign din[5] = bus.hundredthousands;
    assign din[6] = bus.millions;
    assign din[7] = bus.tenmillions;

    // Bypass the snapshot on the capture edge so BLANK_CYC==1 still shows fresh data.
    always_comb begin
        for (int k = 0; k < 8; k++) cur[k] = cap ? din[k] : snap[k];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic allz;
    always_comb begin
        allz = 1'b1;
        lzb  = '0;
        for (int k = 7; k >= 0; k--) begin
            allz = allz & (cur[k] == 4'd0);
            if (k > DP_POS) lzb[k] = allz;
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        nstate = state;
        nidx   = idx;
        ncnt   = cnt + 1'b1;
        cap    = 1'b0;
        case (state)
            BLANK: begin
                cap = (idx == 3'd0) && (cnt == '0);
                if (cnt == CW'(BLANK_CYC - 1)) begin
                    nstate = SHOW;
                    ncnt   = '0;
                end
            end
            SHOW: begin
                if (cnt == CW'(DWELL_CYC - 1)) begin
                    nstate = BLANK;
                    nidx   = idx + 3'd1;
                    ncnt   = '0;
                end
            end
            default: nstate = BLANK;
        endcase

        an_n  = 8'hFF;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        if (nstate == SHOW) begin
            an_n  = ~(8'd1 << nidx);
            seg_n = lzb[nidx] ? 7'h7F : decode(cur[nidx]);
            dp_n  = (nidx != 3'(DP_POS));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= BLANK;
            idx            <= '0;
            cnt            <= '0;
            bus.an         <= 8'hFF;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
            for (int k = 0; k < 8; k++) snap[k] <= '0;
        end else begin
            state          <= nstate;
            idx            <= nidx;
            cnt            <= ncnt;
            bus.an         <= an_n;
            bus.seg        <= seg_n;
            bus.dp         <= dp_n;
            bus.frame_tick <= cap;
            if (cap) for (int k = 0; k < 8; k++) snap[k] <= din[k];
        end
    end
endmodule

// File: tb/tb_seg7_scan8.sv
// Bench for seg7_scan8: frame-position model checked every cycle plus directed literals.
module tb_seg7_scan8;
    localparam int DW  = 4;
    localparam int BL  = 2;
    localparam int DPP = 1;
    localparam int SL  = DW + BL;
    localparam int FR  = 8 * SL;
    localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan8_if bus();
    seg7_scan8 #(.DWELL_CYC(DW), .BLANK_CYC(BL), .DP_POS(DPP)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   total = 0, passed = 0;
    int   t = 0;
    bit   done = 1'b0;
    logic [3:0] msnap [8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    endtask

    function automatic logic [3:0] dig_in(input int k);
        case (k)
            0: return bus.ones;
            1: return bus.tens;
            2: return bus.hundreds;
            3: return bus.thousands;
            4: return bus.tenthousands;
            5: return bus.hundredthousands;
            6: return bus.millions;
            default: return bus.tenmillions;
        endcase
    endfunction

    task automatic set_digits(input logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0);
        bus.tenmillions = d7; bus.millions = d6; bus.hundredthousands = d5; bus.tenthousands = d4;
        bus.thousands = d3; bus.hundreds = d2; bus.tens = d1; bus.ones = d0;
    endtask

    function automatic logic [6:0] exp_seg(input int s);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        bit lead = (s > DPP);
        for (int j = s; j < 8; j++) if (msnap[j] != 4'd0) lead = 1'b0;
        if (lead) return 7'h7F;
`endif
        return SEGTAB[msnap[s]];
    endfunction

    // Model time: t = clocks since reset release; frame position = t mod FR.
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            for (int k = 0; k < 8; k++) msnap[k] = '0;
        end else begin
            if (t % FR == 0) for (int k = 0; k < 8; k++) msnap[k] = dig_in(k);
            t++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                if (rst) begin
                    chk("rst_an", bus.an, 8'hFF);
                    chk("rst_seg", bus.seg, 7'h7F);
                    chk("rst_dp", bus.dp, 1);
                    chk("rst_ft", bus.frame_tick, 0);
                end else begin
                    int p, s, q;
                    p = t % FR;
                    s = p / SL;
                    q = p % SL;
                    chk("ft", bus.frame_tick, (p == 1) ? 1 : 0);
                    if (q < BL) begin
                        chk("blank_an", bus.an, 8'hFF);
                        chk("blank_seg", bus.seg, 7'h7F);
                        chk("blank_dp", bus.dp, 1);
                    end else begin
                        chk("show_an", bus.an, ~(8'd1 << s) & 8'hFF);
                        chk("show_seg", bus.seg, exp_seg(s));
                        chk("show_dp", bus.dp, (s == DPP) ? 0 : 1);
                    end
                end
            end
        end
    end

    task automatic wait_t(input int n);
        int g = 0;
        @(negedge clk);
        while (t != n && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (t != n) chk("wait_timeout", t, n);
    endtask

    localparam logic [6:0] SEQ [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

    initial begin
        rst = 1'b1;
        set_digits(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // All zeros: blank, slot 0, blank, slot 1 with dp
        @(negedge clk); chk("z_t0_an", bus.an, 8'hFF);
        wait_t(1);  chk("z_ft1", bus.frame_tick, 1);
        wait_t(2);  chk("z_an0", bus.an, 8'hFE); chk("z_seg0", bus.seg, 7'h40); chk("z_dp0", bus.dp, 1);
        wait_t(5);  chk("z_an0_end", bus.an, 8'hFE);
        wait_t(6);  chk("z_gap", bus.an, 8'hFF);
        wait_t(8);  chk("z_an1", bus.an, 8'hFD); chk("z_seg1", bus.seg, 7'h40); chk("z_dp1", bus.dp, 0);

        // Digits 8..1 appear in the next frame only
        wait_t(10); set_digits(8, 7, 6, 5, 4, 3, 2, 1);
        wait_t(49); chk("ft_period", bus.frame_tick, 1);
        for (int s = 0; s < 8; s++) begin
            wait_t(FR + BL + s * SL);
            chk("seq_an", bus.an, ~(8'd1 << s) & 8'hFF);
            chk("seq_seg", bus.seg, SEQ[s]);
        end
        wait_t(2 * FR);      chk("wrap_gap", bus.an, 8'hFF);
        wait_t(2 * FR + 2);  chk("wrap_an0", bus.an, 8'hFE);

        // ones=3 staged earlier is frame 3; ones=9 mid-frame only lands in frame 4
        wait_t(2 * FR + 10); bus.ones = 4'd3;
        wait_t(3 * FR + 2);  chk("snap_old", bus.seg, 7'h30);
        wait_t(3 * FR + 4 * SL + 2); bus.ones = 4'd9; bus.tens = 4'hC;
        wait_t(3 * FR + 4 * SL + 3); chk("midframe_hold", bus.an, 8'hEF);
        wait_t(4 * FR + 2);  chk("snap_new", bus.seg, 7'h10);
        wait_t(4 * FR + SL + 2); chk("inv_seg", bus.seg, 7'h3F); chk("inv_dp", bus.dp, 0);
        wait_t(4 * FR + 2 * SL + 2); chk("inv_other", bus.seg, 7'h30);

        // Async reset during SHOW of idx 5
        wait_t(4 * FR + 5 * SL + 2); chk("pre_rst_an", bus.an, 8'hDF);
        #2 rst = 1'b1;
        #1 chk("async_an", bus.an, 8'hFF); chk("async_seg", bus.seg, 7'h7F); chk("async_dp", bus.dp, 1);
        @(posedge clk); #2 rst = 1'b0;
        wait_t(1); chk("restart_ft", bus.frame_tick, 1);
        wait_t(2); chk("restart_an", bus.an, 8'hFE); chk("restart_seg", bus.seg, 7'h10);

        // Leading-zero pattern 0,0,0,0,0,1,0,5
        wait_t(10); set_digits(0, 0, 0, 0, 0, 1, 0, 5);
        wait_t(FR + BL);          chk("lz_s0", bus.seg, 7'h12);
        wait_t(FR + BL + SL);     chk("lz_s1", bus.seg, 7'h40); chk("lz_dp1", bus.dp, 0);
        wait_t(FR + BL + 2 * SL); chk("lz_s2", bus.seg, 7'h79);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        wait_t(FR + BL + 3 * SL); chk("lz_s3", bus.seg, 7'h7F); chk("lz_an3", bus.an, 8'hF7);
        wait_t(FR + BL + 7 * SL); chk("lz_s7", bus.seg, 7'h7F); chk("lz_an7", bus.an, 8'h7F);
`else
        wait_t(FR + BL + 3 * SL); chk("nlz_s3", bus.seg, 7'h40); chk("nlz_an3", bus.an, 8'hF7);
        wait_t(FR + BL + 7 * SL); chk("nlz_s7", bus.seg, 7'h40); chk("nlz_an7", bus.an, 8'h7F);
`endif
        done = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
